key_unexp: RTL and testbench
============================

Name: key_unexp

Overview:
- Inverse AES-128 key schedule: the counterpart of the forward key expansion.
- Takes the final (round-10) round key and regenerates the round keys in reverse order, round 10 down to round 0, one per handshake.
- Sits in the decryption datapath so that decryption can derive keys on the fly from a stored last round key.
- Internally uses the same g transform as the forward schedule: RotWord, SubWord, XOR Rcon.

Parameters:
- NUM_ROUNDS, 10, number of rounds; only 10 (AES-128) is supported.
- RCON_LAST, 8'h36, Rcon used to undo the last forward round.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin; sampled only in IDLE
- key_in  input  128  round-10 key; [127:96]=w0 … [31:0]=w3
- busy  output  1  high from the cycle after an accepted start until return to IDLE
- rk_valid  output  1  rk_out/rk_round hold a valid round key
- rk_ready  input  1  downstream accepts the current round key
- rk_out  output  128  current round key, same word order as key_in
- rk_round  output  4  round index of rk_out (10 down to 0)
- done  output  1  one-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - busy=0, rk_valid=0, done=0.
  - rk_out=0, rk_round=0, internal rcon=0.
- FSM states:
  - IDLE -> OUT on start (key_in latched, round=10, rcon=RCON_LAST).
  - OUT -> OUT on handshake with round>0.
  - OUT -> DONE on handshake with round==0.
  - DONE -> IDLE unconditionally.
- Latency: start accepted at edge t gives rk_valid=1 from t+1, rk_round=10, rk_out=key_in.
- Handshake: a beat transfers on a rising edge with rk_valid && rk_ready.
  - rk_out and rk_round stay stable while rk_valid && !rk_ready.
  - rk_valid never drops in OUT without a transfer.
- On each transfer with round=r>0, the next key (r-1), words v0..v3, is computed from current words w0..w3 in one cycle:
  - v3 = w3^w2
  - v2 = w2^w1
  - v1 = w1^w0
  - v0 = w0 ^ g(v3, rcon)
  - round <= r-1; rcon <= inv_xtime(rcon).
- g(x, rc): RotWord {x[23:0], x[31:24]}, then S-box applied to each byte, then MSB byte XOR rc.
- inv_xtime(b): if b[0]=1, (b>>1)^8'h8d; otherwise b>>1. This gives the sequence 36,1b,80,40,20,10,08,04,02,01.
- Throughput: with rk_ready held high, 11 beats on 11 consecutive cycles.
- done is high in the DONE cycle only, i.e. the cycle after the round-0 transfer. busy=0 and rk_valid=0 in that cycle.
- start while not IDLE (OUT or DONE) is ignored; key_in is not resampled.
- start and reset together: reset wins.
- Reset mid-operation: returns to IDLE the next cycle, clears all outputs, and emits no done.
- rk_ready while rk_valid=0 has no effect.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry SBOX constant array;
  - RCON_LAST;
  - function inv_xtime;
  - the enum state_t {IDLE, OUT, DONE}.
  - The forward-expansion g function reuses the same SBOX.
- One sub-module, sub_word: four parallel combinational S-box lookups on a 32-bit word. It is shared with the forward g function.

Test Plan:
- FIPS-197 Appendix A vector: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and rk_ready=1.
  - Beat 0: rk_round=10, rk_out equals key_in.
  - Beat 1: rk_round=9, ac7766f319fadc2128d12941575c006e.
  - Beat 9: rk_round=1, a0fafe1788542cb123a339392a6c7605.
  - Beat 10: rk_round=0, 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after beat 10; 11 beats take 11 cycles.
- Backpressure: same vector with rk_ready randomly toggled (including 5 idle cycles at round 5). The beat sequence is identical, rk_out is stable while stalled, and done fires exactly once.
- Start while busy: a second start with a different key_in at round 7 is ignored. The remaining beats match the first key and busy stays high.
- Reset mid-operation: assert reset during round 4. Next cycle rk_valid=0, busy=0, rk_out=0, with no done. A fresh start then restarts cleanly at round 10.
- Round-trip: random key K is expanded by a software model to round key 10 and fed in. The round-0 output equals K and every intermediate matches the model, over 1000 keys.
- Simultaneous start+reset from IDLE: the module stays IDLE with all outputs 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-level helpers for the key schedules.
// Latency: none, pure declarations and combinational functions.
// Backpressure: not applicable.
package aes_pkg;

   // Rcon of forward round 10, the first one the inverse schedule has to undo.
   localparam logic [7:0] RCON_LAST = 8'h36;

   typedef enum logic [1:0] {
      IDLE,
      OUT,
      DONE
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Division by x in GF(2^8): undoes xtime, walking Rcon backwards (36,1b,80,...,01).
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return b[0] ? ((b >> 1) ^ 8'h8d) : (b >> 1);
   endfunction

   // Forward-schedule g transform: RotWord, SubWord, then Rcon into the top byte.
   function automatic logic [31:0] g_word(input logic [31:0] x, input logic [7:0] rc);
      logic [31:0] r;
      r = {x[23:0], x[31:24]};
      return {SBOX[r[31:24]] ^ rc, SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
   endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel S-box lookups on a 32-bit word (AES SubWord).
// Latency: combinational.
// Backpressure: not applicable.
module sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] result
);

   // one independent lookup per byte lane
   always_comb begin
      result = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
   end

endmodule

// File: rtl/key_unexp.sv
// Inverse AES-128 key schedule: from the round-10 key emits round keys 10 down to 0.
// Latency: first key one cycle after start, then one key per accepted beat.
// Backpressure: rk_valid/rk_ready; key and round are held while rk_ready is low.
module key_unexp
   import aes_pkg::*;
#(
   parameter int         NUM_ROUNDS = 10,
   parameter logic [7:0] RCON_LAST  = aes_pkg::RCON_LAST
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         done
);

   state_t       state;
   state_t       next_state;
   logic [127:0] key_q;
   logic [3:0]   round_q;
   logic [7:0]   rcon_q;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  v0, v1, v2, v3;
   logic [31:0]  rot_v3;
   logic [31:0]  sub_v3;
   logic         xfer;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // Words 1..3 of the previous round key fall out of adjacent XORs; word 0 then
   // needs g applied to the recovered word 3.
   assign v3     = w3 ^ w2;
   assign v2     = w2 ^ w1;
   assign v1     = w1 ^ w0;
   assign rot_v3 = {v3[23:0], v3[31:24]};

   sub_word u_sub_word (
      .word   (rot_v3),
      .result (sub_v3)
   );

   assign v0 = w0 ^ sub_v3 ^ {rcon_q, 24'h000000};

   assign xfer     = (state == OUT) && rk_ready;
   assign rk_valid = (state == OUT);
   assign busy     = (state == OUT);
   assign done     = (state == DONE);
   assign rk_out   = key_q;
   assign rk_round = round_q;

   // next-state selection: leave OUT only once round 0 has been handed over
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = OUT;
         OUT:     if (xfer && (round_q == 4'd0)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // state, current key, round index and Rcon; key only steps on an accepted beat
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         rcon_q  <= '0;
      end else begin
         state <= next_state;
         if ((state == IDLE) && start) begin
            key_q   <= key_in;
            round_q <= 4'(NUM_ROUNDS);
            rcon_q  <= RCON_LAST;
         end else if (xfer && (round_q != 4'd0)) begin
            key_q   <= {v0, v1, v2, v3};
            round_q <= round_q - 4'd1;
            rcon_q  <= inv_xtime(rcon_q);
         end
      end
   end

endmodule

// File: tb/tb_key_unexp.sv
// Randomised bench for key_unexp against a forward AES-128 key expansion model.
// Latency: checks first key one cycle after start and per-beat ordering.
// Backpressure: drives random rk_ready and forced stalls; held outputs are re-checked.
module tb_key_unexp;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         done;

   always #5 clk = ~clk;

   key_unexp dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .done     (done)
   );

   int           n_checks = 0;
   int           n_errors = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];
   logic [127:0] got_rk [11];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv, s, t;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv;
         t = inv;
         for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         sb[a] = s ^ 8'h63;
      end
   endtask

   // Forward AES-128 key expansion; fills exp_rk[0..10]
   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One full run from IDLE; expected keys come from exp_rk
   task automatic session(input logic [127:0] k10, input int pct, input bit stall5,
                          input bit late_start, input string tag);
      int beat, cyc, stalls;
      bit xfer;
      start    = 1'b1;
      key_in   = k10;
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      beat   = 0;
      cyc    = 0;
      stalls = 0;
      while (beat < 11 && cyc < 400) begin
         chk({tag, " valid"}, 128'(rk_valid), 128'(1));
         chk({tag, " busy"}, 128'(busy), 128'(1));
         chk({tag, " done_early"}, 128'(done), 128'(0));
         chk({tag, " round"}, 128'(rk_round), 128'(10 - beat));
         chk({tag, " key"}, rk_out, exp_rk[10 - beat]);
         if (late_start && beat == 3) begin
            start  = 1'b1;
            key_in = ~k10;
         end
         if (stall5 && beat == 5 && stalls < 5) begin
            rk_ready = 1'b0;
            stalls++;
         end else begin
            rk_ready = ($urandom_range(1, 100) <= pct);
         end
         xfer = rk_ready;
         if (xfer) got_rk[10 - beat] = rk_out;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (xfer) beat++;
      end
      chk({tag, " beats"}, 128'(beat), 128'(11));
      if (pct == 100 && !stall5) chk({tag, " cycles"}, 128'(cyc), 128'(11));
      if (stall5) chk({tag, " stalls"}, 128'(stalls), 128'(5));
      chk({tag, " done"}, 128'(done), 128'(1));
      chk({tag, " busy_done"}, 128'(busy), 128'(0));
      chk({tag, " valid_done"}, 128'(rk_valid), 128'(0));
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, " done_once"}, 128'(done), 128'(0));
      chk({tag, " valid_idle"}, 128'(rk_valid), 128'(0));
      chk({tag, " busy_idle"}, 128'(busy), 128'(0));
   endtask

   initial begin
      logic [127:0] k;
      int cyc;
      reset    = 1'b1;
      start    = 1'b0;
      key_in   = '0;
      rk_ready = 1'b0;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst valid", 128'(rk_valid), 128'(0));
      chk("rst done", 128'(done), 128'(0));
      chk("rst key", rk_out, 128'(0));
      chk("rst round", 128'(rk_round), 128'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      // FIPS-197 Appendix A, full throughput
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      session(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, 1'b0, 1'b0, "fips");
      chk("fips r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("fips r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
      chk("fips r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // backpressure with a forced 5-cycle stall at round 5
      session(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 50, 1'b1, 1'b0, "bp");
      chk("bp r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // second start at round 7 must be ignored
      session(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, 1'b0, 1'b1, "busy_start");

      // reset during round 4
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      start    = 1'b1;
      key_in   = exp_rk[10];
      rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 0;
      while (rk_round != 4'd4 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid round4", 128'(rk_round), 128'(4));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid valid", 128'(rk_valid), 128'(0));
      chk("mid busy", 128'(busy), 128'(0));
      chk("mid key", rk_out, 128'(0));
      chk("mid round", 128'(rk_round), 128'(0));
      chk("mid done", 128'(done), 128'(0));
      @(posedge clk); #1;
      chk("mid done_after", 128'(done), 128'(0));
      chk("mid valid_after", 128'(rk_valid), 128'(0));
      session(exp_rk[10], 100, 1'b0, 1'b0, "restart");
      chk("restart r0", got_rk[0], k);

      // start together with reset from IDLE
      reset  = 1'b1;
      start  = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      chk("sr busy", 128'(busy), 128'(0));
      chk("sr valid", 128'(rk_valid), 128'(0));
      chk("sr key", rk_out, 128'(0));
      chk("sr done", 128'(done), 128'(0));
      @(posedge clk); #1;
      chk("sr busy_after", 128'(busy), 128'(0));
      chk("sr valid_after", 128'(rk_valid), 128'(0));

      // round-trip over random keys
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         expand(k);
         session(exp_rk[10], 75, 1'b0, 1'b0, "rt");
         chk("rt r0", got_rk[0], k);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
